// File: rtl/channel_mux_pkg.sv
// Shared types and constants for the 8:1 round-robin channel multiplexer.
package channel_mux_pkg;

  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned CH_IDX_W = 3;

  typedef logic [CH_IDX_W-1:0] chan_idx_t;

  typedef enum logic {
    ST_ARB,
    ST_LOCK
  } arb_state_e;

endpackage

// File: rtl/channel_mux_arb_rr_arbiter.sv
// Combinational round-robin priority search: first requester at or after ptr_i, modulo NUM_CH.
module rr_arbiter
  import channel_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  chan_idx_t         ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output chan_idx_t         grant_idx_o,
  output logic              any_grant_o
);

  chan_idx_t idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    idx         = ptr_i;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      // 3-bit addition wraps naturally, giving the modulo-8 search order.
      idx = ptr_i + chan_idx_t'(i);
      if (!any_grant_o && req_i[idx]) begin
        any_grant_o  = 1'b1;
        grant_idx_o  = idx;
        grant_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_mux_arb.sv
// 8:1 round-robin arbitrated channel mux with a registered valid/ready output stage.
// Optional burst locking (in_last_i/out_last_o, ARB/LOCK FSM) under CHANNEL_MUX_BURST_EN.
module channel_mux_arb
  import channel_mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = channel_mux_pkg::NUM_CH
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_CH-1:0]                    in_valid_i,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    in_data_i,
  output logic [NUM_CH-1:0]                    in_ready_o,
  output logic                                 out_valid_o,
  output logic [DATA_WIDTH-1:0]                out_data_o,
  output logic [2:0]                           out_sel_o,
  input  logic                                 out_ready_i
`ifdef CHANNEL_MUX_BURST_EN
  ,
  input  logic [NUM_CH-1:0]                    in_last_i,
  output logic                                 out_last_o
`endif
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  chan_idx_t             out_sel_q,   out_sel_d;
  chan_idx_t             ptr_q,       ptr_d;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  chan_idx_t         grant_idx;
  logic              any_grant;
  logic              load_en;
  logic              accept;

`ifdef CHANNEL_MUX_BURST_EN
  arb_state_e        state_q, state_d;
  chan_idx_t         lock_ch_q, lock_ch_d;
  logic              out_last_q, out_last_d;
  logic [NUM_CH-1:0] lock_mask;

  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_ch_q] = 1'b1;
    req                  = (state_q == ST_LOCK) ? (in_valid_i & lock_mask) : in_valid_i;
  end
`else
  assign req = in_valid_i;
`endif

  rr_arbiter u_rr_arbiter (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  assign load_en    = !out_valid_q || out_ready_i;
  assign accept     = any_grant && load_en && !rst_i;
  assign in_ready_o = rst_i ? '0 : (grant & {NUM_CH{load_en}});

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef CHANNEL_MUX_BURST_EN
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
`endif
    if (load_en) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i[grant_idx];
        out_sel_d   = grant_idx;
        ptr_d       = grant_idx + chan_idx_t'(1);
`ifdef CHANNEL_MUX_BURST_EN
        out_last_d  = in_last_i[grant_idx];
        // In LOCK only lock_ch can be granted, so grant_idx+1 equals lock_ch+1 on exit.
        if (state_q == ST_ARB && !in_last_i[grant_idx]) begin
          state_d   = ST_LOCK;
          lock_ch_d = grant_idx;
        end else if (state_q == ST_LOCK && in_last_i[grant_idx]) begin
          state_d   = ST_ARB;
        end
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef CHANNEL_MUX_BURST_EN
      state_q     <= ST_ARB;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef CHANNEL_MUX_BURST_EN
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;
`ifdef CHANNEL_MUX_BURST_EN
  assign out_last_o  = out_last_q;
`endif

endmodule
